// File: rtl/mac_window_sequencer.sv
// Sequences one shared multiply-accumulate unit through a TAPS-point dot product:
// it flushes the MAC, feeds one window/coef pair per cycle, drains, then holds the result.
module mac_window_sequencer #(
  parameter int I_OPP_W = 4,
  parameter int O_OPP_W = 2*I_OPP_W,
  parameter int TAPS    = 9,
  parameter int MAC_LAT = 2
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [TAPS*I_OPP_W-1:0] win_data,
  input  logic [TAPS*I_OPP_W-1:0] coef,
  input  logic                    win_valid,
  output logic                    win_ready,
  output logic                    mac_reset,
  output logic [I_OPP_W-1:0]      mac_data,
  output logic [I_OPP_W-1:0]      mac_multi,
  input  logic [O_OPP_W-1:0]      mac_result,
  input  logic                    mac_overflow,
  output logic [O_OPP_W-1:0]      out_data,
  output logic                    out_overflow,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int CNT_MAX = (TAPS > MAC_LAT) ? TAPS : MAC_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MAC_LAT - 1);
  localparam logic [CNT_W-1:0] TAP_LAST = CNT_W'(TAPS - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, OUT} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [TAPS*I_OPP_W-1:0]   win_lat;
  logic [TAPS*I_OPP_W-1:0]   coef_lat;
  logic                      ovf_acc;

  // Operands are registered one cycle ahead of the state they belong to, so the
  // latched vectors are shifted down and tap 0 always sits in the low slot.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      cnt          <= '0;
      win_lat      <= '0;
      coef_lat     <= '0;
      ovf_acc      <= 1'b0;
      win_ready    <= 1'b1;
      mac_reset    <= 1'b1;
      mac_data     <= '0;
      mac_multi    <= '0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            win_lat   <= win_data;
            coef_lat  <= coef;
            win_ready <= 1'b0;
            cnt       <= '0;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          ovf_acc <= 1'b0;
          if (cnt == LAT_LAST) begin
            cnt       <= '0;
            mac_reset <= 1'b0;
            mac_data  <= win_lat[I_OPP_W-1:0];
            mac_multi <= coef_lat[I_OPP_W-1:0];
            win_lat   <= win_lat >> I_OPP_W;
            coef_lat  <= coef_lat >> I_OPP_W;
            state     <= FEED;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FEED: begin
          ovf_acc <= ovf_acc | mac_overflow;
          if (cnt == TAP_LAST) begin
            cnt       <= '0;
            mac_data  <= '0;
            mac_multi <= '0;
            state     <= DRAIN;
          end else begin
            cnt       <= cnt + 1'b1;
            mac_data  <= win_lat[I_OPP_W-1:0];
            mac_multi <= coef_lat[I_OPP_W-1:0];
            win_lat   <= win_lat >> I_OPP_W;
            coef_lat  <= coef_lat >> I_OPP_W;
          end
        end
        DRAIN: begin
          ovf_acc <= ovf_acc | mac_overflow;
          if (cnt == LAT_LAST) begin
            cnt          <= '0;
            out_data     <= mac_result;
            out_overflow <= ovf_acc | mac_overflow;
            out_valid    <= 1'b1;
            mac_reset    <= 1'b1;
            state        <= OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            win_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
